// File: rtl/midi_preset_ctrl.sv
// Preset engine for the MIDI pedal: loads BUTTONS_CNT slots from SPI flash,
// learns captured MIDI commands into slots, saves the table and plays slots back.
module midi_preset_ctrl #(
    parameter int unsigned BUTTONS_CNT = 4,
    parameter logic [23:0] MEMADDR     = 24'h1ffd80,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned FORCE_CH    = 0,
    parameter int unsigned IW          = $clog2(BUTTONS_CNT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] btn_index,
    input  logic          save_mode,
    input  logic          learn_valid,
    input  logic [7:0]    status_in,
    input  logic [7:0]    data1_in,
    input  logic [7:0]    data2_in,
    input  logic [1:0]    bytes_cnt_in,
    input  logic          save_req,
    output logic [7:0]    status,
    output logic [7:0]    data1,
    output logic [7:0]    data2,
    output logic [7:0]    cmd_bits_cnt,
    output logic          cmd_trigger_out,
    output logic [23:0]   spi_adr_o,
    output logic [31:0]   spi_dat_o,
    output logic          spi_we_o,
    output logic          spi_stb_o,
    output logic          spi_tga_o,
    input  logic [31:0]   spi_dat_i,
    input  logic          spi_ack_i,
    input  logic          spi_rty_i,
    output logic          busy,
    output logic          loaded,
    output logic          fail
);

    localparam int unsigned RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {
        LOAD_REQ, LOAD_WAIT, IDLE, ERASE_REQ, ERASE_WAIT, WRITE_REQ, WRITE_WAIT, FAIL
    } state_t;

    state_t          state, state_d, retry_st;
    logic [IW-1:0]   idx, idx_d;
    logic [RW-1:0]   retry, retry_d;
    logic            stb_d, we_d, tga_d, loaded_d, fail_d;
    logic [23:0]     adr_d;
    logic [31:0]     dat_d;
    logic            load_wr_c, save_go_c, rty_hit_c;

    logic [31:0]        slot_mem [0:BUTTONS_CNT];
    logic [BUTTONS_CNT:0] valid;
    logic               dirty;
    logic [IW-1:0]      btn_prev;

    logic        btn_in_range_c, learn_ok_c, play_c, word_ok_c;
    logic [23:0] slot_adr_c;
    logic [31:0] play_word_c;
    logic [7:0]  bits_c;

    assign btn_in_range_c = (btn_index != '0) && (32'(btn_index) <= BUTTONS_CNT);
    assign learn_ok_c     = learn_valid && save_mode && btn_in_range_c && (bytes_cnt_in != 2'd0)
                            && (state != LOAD_REQ) && (state != LOAD_WAIT);
    assign play_c         = (btn_index != btn_prev) && btn_in_range_c && !save_mode && valid[btn_index];
    assign play_word_c    = slot_mem[btn_index];
    assign bits_c         = spi_dat_i[7:0];
    assign word_ok_c      = (spi_dat_i != 32'hFFFF_FFFF) && spi_dat_i[31]
                            && ((bits_c == 8'd10) || (bits_c == 8'd20) || (bits_c == 8'd30));
    assign slot_adr_c     = MEMADDR + 24'({idx, 2'b00}) - 24'd4;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= LOAD_REQ;
            idx       <= IW'(1);
            retry     <= '0;
            spi_stb_o <= 1'b0;
            spi_we_o  <= 1'b0;
            spi_tga_o <= 1'b0;
            spi_adr_o <= '0;
            spi_dat_o <= '0;
            busy      <= 1'b0;
            loaded    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            retry     <= retry_d;
            spi_stb_o <= stb_d;
            spi_we_o  <= we_d;
            spi_tga_o <= tga_d;
            spi_adr_o <= adr_d;
            spi_dat_o <= dat_d;
            busy      <= (state_d != IDLE) && (state_d != FAIL);
            loaded    <= loaded_d;
            fail      <= fail_d;
        end
    end

    // Flash sequencer: request, wait for ack/rty, and hold off until ack releases.
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        retry_d   = retry;
        stb_d     = spi_stb_o;
        we_d      = spi_we_o;
        tga_d     = spi_tga_o;
        adr_d     = spi_adr_o;
        dat_d     = spi_dat_o;
        loaded_d  = loaded;
        fail_d    = fail;
        load_wr_c = 1'b0;
        save_go_c = 1'b0;
        rty_hit_c = 1'b0;
        retry_st  = state;
        case (state)
            LOAD_REQ: if (!spi_ack_i) begin
                stb_d = 1'b1; we_d = 1'b0; tga_d = 1'b0; adr_d = slot_adr_c;
                state_d = LOAD_WAIT;
            end
            LOAD_WAIT: if (spi_ack_i) begin
                stb_d = 1'b0; retry_d = '0; load_wr_c = 1'b1;
                if (idx == IW'(BUTTONS_CNT)) begin
                    loaded_d = 1'b1; state_d = IDLE;
                end else begin
                    idx_d = idx + IW'(1); state_d = LOAD_REQ;
                end
            end else if (spi_rty_i) begin
                rty_hit_c = 1'b1; retry_st = LOAD_REQ;
            end
            IDLE: if (save_req && (dirty || learn_ok_c)) begin
                save_go_c = 1'b1; state_d = ERASE_REQ;
            end
            ERASE_REQ: if (!spi_ack_i) begin
                stb_d = 1'b1; we_d = 1'b1; tga_d = 1'b1; adr_d = MEMADDR;
                state_d = ERASE_WAIT;
            end
            ERASE_WAIT: if (spi_ack_i) begin
                stb_d = 1'b0; retry_d = '0; idx_d = IW'(1); state_d = WRITE_REQ;
            end else if (spi_rty_i) begin
                rty_hit_c = 1'b1; retry_st = ERASE_REQ;
            end
            WRITE_REQ: if (!spi_ack_i) begin
                stb_d = 1'b1; we_d = 1'b1; tga_d = 1'b0; adr_d = slot_adr_c;
                dat_d = valid[idx] ? slot_mem[idx] : 32'hFFFF_FFFF;
                state_d = WRITE_WAIT;
            end
            WRITE_WAIT: if (spi_ack_i) begin
                stb_d = 1'b0; retry_d = '0;
                if (idx == IW'(BUTTONS_CNT)) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx + IW'(1); state_d = WRITE_REQ;
                end
            end else if (spi_rty_i) begin
                rty_hit_c = 1'b1; retry_st = WRITE_REQ;
            end
            default: ;
        endcase
        if (rty_hit_c) begin
            stb_d = 1'b0;
            if (32'(retry) + 32'd1 >= MAX_RETRY) begin
                fail_d = 1'b1; state_d = FAIL;
            end else begin
                retry_d = retry + RW'(1); state_d = retry_st;
            end
        end
    end

    // Slot table, validity, dirty flag and playback registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid           <= '0;
            dirty           <= 1'b0;
            btn_prev        <= '0;
            status          <= '0;
            data1           <= '0;
            data2           <= '0;
            cmd_bits_cnt    <= '0;
            cmd_trigger_out <= 1'b0;
        end else begin
            btn_prev        <= btn_index;
            cmd_trigger_out <= play_c;
            if (play_c) begin
                status       <= (FORCE_CH == 0) ? play_word_c[31:24]
                                                : {play_word_c[31:28], 4'(FORCE_CH - 1)};
                data1        <= play_word_c[23:16];
                data2        <= play_word_c[15:8];
                cmd_bits_cnt <= play_word_c[7:0];
            end
            if (load_wr_c)  valid[idx]       <= word_ok_c;
            if (learn_ok_c) valid[btn_index] <= 1'b1;
            if (save_go_c)       dirty <= 1'b0;
            else if (learn_ok_c) dirty <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_wr_c && word_ok_c) slot_mem[idx] <= spi_dat_i;
        if (learn_ok_c) slot_mem[btn_index] <= {status_in, data1_in, data2_in, 8'(bytes_cnt_in) * 8'd10};
    end

endmodule

// File: tb/tb_midi_preset_ctrl.sv
// Scoreboard bench for midi_preset_ctrl: two instances (FORCE_CH 0 and 5) share
// stimulus and a behavioural flash; expected SPI requests and playbacks are queued.
module tb_midi_preset_ctrl;

    localparam logic [23:0] MEMADDR = 24'h1ffd80;

    typedef struct {
        logic        we, tga, chk_dat;
        logic [23:0] adr;
        logic [31:0] dat;
    } spi_exp_t;

    typedef struct {
        logic [7:0] s0, s1, d1, d2, b;
    } play_exp_t;

    logic clk = 1'b0, rst = 1'b0;
    logic [2:0] btn = '0;
    logic save_mode = 0, learn_valid = 0, save_req = 0;
    logic [7:0] status_in = '0, data1_in = '0, data2_in = '0;
    logic [1:0] bytes_cnt_in = '0;
    logic [31:0] spi_dat_i = '0;
    logic spi_ack_i = 0, spi_rty_i = 0;

    logic [7:0] st0, d10, d20, bc0, st1, d11, d21, bc1;
    logic trg0, trg1, we0, we1, stb0, stb1, tga0, tga1;
    logic busy0, busy1, ld0, ld1, fl0, fl1;
    logic [23:0] adr0, adr1;
    logic [31:0] dat0, dat1;

    int n_checks = 0, n_fail = 0;
    spi_exp_t  exp_spi[$];
    play_exp_t exp_play[$];
    logic [31:0] flash [int];
    int rty_left = 0;
    bit stall_writes = 0;

    logic [31:0] m_word [1:4];
    bit          m_valid [1:4];
    bit          m_dirty;
    int          m_prev;

    always #5 clk = ~clk;

    midi_preset_ctrl #(.FORCE_CH(0)) u_dut0 (
        .clk(clk), .rst(rst), .btn_index(btn), .save_mode(save_mode), .learn_valid(learn_valid),
        .status_in(status_in), .data1_in(data1_in), .data2_in(data2_in), .bytes_cnt_in(bytes_cnt_in),
        .save_req(save_req), .status(st0), .data1(d10), .data2(d20), .cmd_bits_cnt(bc0),
        .cmd_trigger_out(trg0), .spi_adr_o(adr0), .spi_dat_o(dat0), .spi_we_o(we0), .spi_stb_o(stb0),
        .spi_tga_o(tga0), .spi_dat_i(spi_dat_i), .spi_ack_i(spi_ack_i), .spi_rty_i(spi_rty_i),
        .busy(busy0), .loaded(ld0), .fail(fl0));

    midi_preset_ctrl #(.FORCE_CH(5)) u_dut1 (
        .clk(clk), .rst(rst), .btn_index(btn), .save_mode(save_mode), .learn_valid(learn_valid),
        .status_in(status_in), .data1_in(data1_in), .data2_in(data2_in), .bytes_cnt_in(bytes_cnt_in),
        .save_req(save_req), .status(st1), .data1(d11), .data2(d21), .cmd_bits_cnt(bc1),
        .cmd_trigger_out(trg1), .spi_adr_o(adr1), .spi_dat_o(dat1), .spi_we_o(we1), .spi_stb_o(stb1),
        .spi_tga_o(tga1), .spi_dat_i(spi_dat_i), .spi_ack_i(spi_ack_i), .spi_rty_i(spi_rty_i),
        .busy(busy1), .loaded(ld1), .fail(fl1));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd(input logic [23:0] a);
        return flash.exists(int'(a)) ? flash[int'(a)] : 32'hFFFF_FFFF;
    endfunction

    function automatic bit word_ok(input logic [31:0] w);
        return (w != 32'hFFFF_FFFF) && w[31] && (w[7:0] == 8'd10 || w[7:0] == 8'd20 || w[7:0] == 8'd30);
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Flash model: random latency, optional retries, ack held one or two cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && stb0 && !spi_ack_i && !spi_rty_i && !(stall_writes && we0 && !tga0)) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                if (rst && stb0) begin
                    @(posedge clk); #1;
                    if (rty_left > 0) begin
                        rty_left--;
                        spi_rty_i = 1'b1;
                        @(posedge clk); #1;
                        spi_rty_i = 1'b0;
                    end else begin
                        if (!we0)     spi_dat_i = rd(adr0);
                        else if (tga0) flash.delete();
                        else          flash[int'(adr0)] = dat0;
                        spi_ack_i = 1'b1;
                        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
                        spi_ack_i = 1'b0;
                    end
                end
            end
        end
    end

    // SPI monitor: each new request is compared with the head of the queue, popped on ack.
    logic stb_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            stb_prev = 1'b0;
        end else begin
            if (stb0 && !stb_prev) begin
                if (exp_spi.size() == 0) begin
                    check("spi_unexpected_req", {we0, tga0, adr0}, 0);
                end else begin
                    check("spi_we",  we0,  exp_spi[0].we);
                    check("spi_tga", tga0, exp_spi[0].tga);
                    check("spi_adr", adr0, exp_spi[0].adr);
                    if (exp_spi[0].chk_dat) check("spi_dat", dat0, exp_spi[0].dat);
                    check("spi_inst1_bus", {stb1, we1, tga1, adr1, dat1}, {stb0, we0, tga0, adr0, dat0});
                end
            end
            if (stb0 && spi_ack_i && exp_spi.size() > 0) void'(exp_spi.pop_front());
            stb_prev = stb0;
        end
    end

    // Playback monitor.
    always @(negedge clk) begin
        if (rst && (trg0 || trg1)) begin
            if (exp_play.size() == 0) begin
                check("play_unexpected_trigger", {trg0, trg1, st0}, 0);
            end else begin
                play_exp_t e;
                e = exp_play.pop_front();
                check("play_trig_both", {trg0, trg1}, 2'b11);
                check("play_status_fc0", st0, e.s0);
                check("play_status_fc5", st1, e.s1);
                check("play_data", {d10, d20, bc0}, {e.d1, e.d2, e.b});
                check("play_data_inst1", {d11, d21, bc1}, {e.d1, e.d2, e.b});
            end
        end
    end

    task automatic press(input int k, input bit sm);
        btn = 3'(k);
        save_mode = sm;
        if (k != m_prev && k >= 1 && k <= 4 && !sm && m_valid[k]) begin
            play_exp_t e;
            e.s0 = m_word[k][31:24];
            e.s1 = {m_word[k][31:28], 4'd4};
            e.d1 = m_word[k][23:16];
            e.d2 = m_word[k][15:8];
            e.b  = m_word[k][7:0];
            exp_play.push_back(e);
        end
        m_prev = k;
        step();
    endtask

    task automatic push_save();
        spi_exp_t e;
        e = '{we: 1'b1, tga: 1'b1, chk_dat: 1'b0, adr: MEMADDR, dat: 32'h0};
        exp_spi.push_back(e);
        for (int k = 1; k <= 4; k++) begin
            e = '{we: 1'b1, tga: 1'b0, chk_dat: 1'b1, adr: MEMADDR + 24'(4 * (k - 1)),
                  dat: m_valid[k] ? m_word[k] : 32'hFFFF_FFFF};
            exp_spi.push_back(e);
        end
        m_dirty = 0;
    endtask

    task automatic learn(input int k, input logic [7:0] s, d1, d2, input logic [1:0] cnt, input bit with_save);
        press(k, 1);
        status_in = s; data1_in = d1; data2_in = d2; bytes_cnt_in = cnt;
        learn_valid = 1'b1;
        save_req = with_save;
        if (k >= 1 && k <= 4 && cnt != 0) begin
            m_word[k]  = {s, d1, d2, 8'(cnt * 10)};
            m_valid[k] = 1;
            m_dirty    = 1;
        end
        if (with_save && m_dirty) push_save();
        step();
        learn_valid = 1'b0;
        save_req = 1'b0;
    endtask

    task automatic wait_flash_idle(input string name);
        for (int i = 0; i < 800 && (busy0 || exp_spi.size() != 0); i++) step();
        check({name, "_busy"}, {busy0, busy1}, 2'b00);
        check({name, "_queue"}, exp_spi.size(), 0);
    endtask

    task automatic reset_model();
        for (int k = 1; k <= 4; k++) m_valid[k] = 0;
        m_dirty = 0;
        m_prev = 0;
    endtask

    task automatic start_load();
        reset_model();
        for (int k = 1; k <= 4; k++) begin
            spi_exp_t e;
            logic [31:0] w;
            w = rd(MEMADDR + 24'(4 * (k - 1)));
            e = '{we: 1'b0, tga: 1'b0, chk_dat: 1'b0, adr: MEMADDR + 24'(4 * (k - 1)), dat: 32'h0};
            exp_spi.push_back(e);
            m_valid[k] = word_ok(w);
            m_word[k]  = w;
        end
        rst = 1'b1;
    endtask

    task automatic wait_loaded(input string name);
        for (int i = 0; i < 800 && !ld0; i++) step();
        check(name, {ld0, ld1, fl0, fl1}, 4'b1100);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        flash[int'(MEMADDR)]      = 32'hB02E7F1E;
        flash[int'(MEMADDR + 4)]  = 32'hFFFFFFFF;
        flash[int'(MEMADDR + 8)]  = 32'hC0420014;
        flash[int'(MEMADDR + 12)] = 32'h00000000;
        rty_left = 2;
        repeat (3) step();
        check("reset_outputs_inst0", {st0, d10, d20, bc0, trg0, adr0, dat0, we0, stb0, tga0, busy0, ld0, fl0}, 0);
        check("reset_outputs_inst1", {st1, d11, d21, bc1, trg1, adr1, dat1, we1, stb1, tga1, busy1, ld1, fl1}, 0);

        // Initial load with two retries on the first read.
        start_load();
        step();
        check("busy_during_load", busy0, 1'b1);
        wait_loaded("initial_load");
        wait_flash_idle("after_load");

        // Directed playback: slot 3, hold, invalid slot 2, slot 1.
        press(3, 0);
        repeat (100) step();
        press(2, 0);
        press(0, 0);
        press(1, 0);
        repeat (3) step();

        for (int i = 0; i < 40; i++) begin
            press(int'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) step();
        end
        press(0, 0);
        repeat (3) step();
        check("play_queue_drained", exp_play.size(), 0);

        // Learn slot 2 and save the table.
        learn(2, 8'hB0, 8'h2F, 8'h7F, 2'd3, 0);
        press(0, 1);
        save_req = 1'b1;
        if (m_dirty) push_save();
        step();
        save_req = 1'b0;
        wait_flash_idle("save1");
        check("flash_slot2", rd(MEMADDR + 4), 32'hB02F7F1E);

        // Rejected learns then a save with nothing dirty.
        learn(1, 8'h90, 8'h01, 8'h02, 2'd0, 0);
        learn(6, 8'h90, 8'h01, 8'h02, 2'd2, 0);
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        repeat (20) step();
        check("clean_save_ignored", {busy0, stb0}, 2'b00);

        // Learn and save in the same cycle.
        learn(4, 8'h91, 8'h3C, 8'h64, 2'd2, 1);
        wait_flash_idle("save2");
        check("flash_slot4", rd(MEMADDR + 12), 32'h913C6414);
        press(0, 0);
        press(4, 0);
        press(2, 0);
        press(1, 0);
        press(0, 0);
        repeat (3) step();

        // Reset while a write is outstanding.
        learn(3, 8'hC5, 8'h07, 8'h00, 2'd1, 0);
        press(0, 0);
        stall_writes = 1'b1;
        save_req = 1'b1;
        push_save();
        step();
        save_req = 1'b0;
        for (int i = 0; i < 300 && !(stb0 && we0 && !tga0); i++) step();
        check("reached_write_wait", {stb0, we0, tga0}, 3'b110);
        repeat (3) step();
        rst = 1'b0;
        exp_spi.delete();
        @(posedge clk);
        @(negedge clk);
        check("stb_drop_on_reset", {stb0, stb1}, 2'b00);
        step();
        check("reset_mid_write_outputs", {busy0, ld0, fl0, trg0, st0}, 0);
        stall_writes = 1'b0;
        start_load();
        wait_loaded("reload");
        wait_flash_idle("after_reload");
        press(1, 0);
        press(3, 0);
        press(0, 0);
        repeat (3) step();

        // Retries exhausted: FAIL, then learn and playback still work.
        rst = 1'b0;
        repeat (2) step();
        exp_spi.delete();
        rty_left = 3;
        reset_model();
        begin
            spi_exp_t e;
            e = '{we: 1'b0, tga: 1'b0, chk_dat: 1'b0, adr: MEMADDR, dat: 32'h0};
            exp_spi.push_back(e);
        end
        rst = 1'b1;
        for (int i = 0; i < 300 && !fl0; i++) step();
        check("fail_state", {fl0, fl1, busy0, stb0, ld0}, 5'b11000);
        exp_spi.delete();
        learn(1, 8'hB0, 8'h11, 8'h22, 2'd2, 0);
        press(0, 0);
        press(1, 0);
        press(0, 0);
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        repeat (10) step();
        check("save_in_fail_ignored", {busy0, stb0, fl0}, 3'b001);

        check("final_spi_queue", exp_spi.size(), 0);
        check("final_play_queue", exp_play.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
